// File: rtl/ram_arbiter_if.sv
// One memory bus with a read/write/waitrequest/valid handshake.
// master drives the command; slave answers with data, valid and waitrq.
interface ram_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              waitrq;

  modport master (output addr, data_in, read, write, input data_out, valid, waitrq);
  modport slave  (input addr, data_in, read, write, output data_out, valid, waitrq);
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester DRAM arbiter: whole transactions, round-robin on ties.
// Define RAM_ARB_A_PRIORITY_EN to make port A win every tie instead.
module ram_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  ram_arbiter_if.slave   a,
  ram_arbiter_if.slave   b,
  ram_arbiter_if.master  ram,
  output logic           grant_b,
  output logic           timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RDWAIT = 2'd2} state_t;

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_grant_b;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_req_a;
  logic              w_req_b;
  logic              w_pick_b;
  logic              w_own_rd;
  logic              w_own_wr;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_data;
  logic              w_done;
  logic              w_done_vld;
  logic              w_timeout;

  assign w_req_a = a.read | a.write;
  assign w_req_b = b.read | b.write;

`ifdef RAM_ARB_A_PRIORITY_EN
  assign w_pick_b = w_req_b && !w_req_a;
`else
  logic r_last_b;

  // On a tie the port that did not win last time gets the bus.
  assign w_pick_b = w_req_b && (!w_req_a || !r_last_b);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_last_b <= 1'b1;
    end else if (r_state == IDLE && (w_req_a || w_req_b)) begin
      r_last_b <= w_pick_b;
    end
  end
`endif

  assign w_own_rd   = r_grant_b ? b.read    : a.read;
  assign w_own_wr   = r_grant_b ? b.write   : a.write;
  assign w_own_addr = r_grant_b ? b.addr    : a.addr;
  assign w_own_data = r_grant_b ? b.data_in : a.data_in;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_grant_b     <= 1'b0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && (w_req_a || w_req_b)) begin
        r_grant_b <= w_pick_b;
      end
      if (r_state != RDWAIT) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(RD_TIMEOUT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_done       = 1'b0;
    w_done_vld   = 1'b0;
    w_timeout    = 1'b0;
    ram.addr     = '0;
    ram.data_in  = '0;
    ram.read     = 1'b0;
    ram.write    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_a || w_req_b) begin
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        ram.addr    = w_own_addr;
        ram.data_in = w_own_data;
        ram.write   = w_own_wr;
        ram.read    = w_own_rd && !w_own_wr;
        if (!w_own_rd && !w_own_wr) begin
          w_state_nxt = IDLE;
        end else if (!ram.waitrq) begin
          if (w_own_wr) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else if (ram.valid) begin
            w_done      = 1'b1;
            w_done_vld  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        // Commands stay low here so the DRAM never sees a second read.
        ram.addr    = w_own_addr;
        ram.data_in = w_own_data;
        if (ram.valid) begin
          w_done      = 1'b1;
          w_done_vld  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(RD_TIMEOUT)) begin
          w_done      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign a.waitrq   = !(w_done && !r_grant_b);
  assign a.valid    = w_done_vld && !r_grant_b;
  assign b.waitrq   = !(w_done && r_grant_b);
  assign b.valid    = w_done_vld && r_grant_b;
  assign a.data_out = ram.data_out;
  assign b.data_out = ram.data_out;

  assign grant_b     = r_grant_b;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single 22-bit-address, 16-bit-data DRAM master port between two requesters: port A (audio play/record engine) and port B (image/frame buffer engine). It serialises whole transactions, one at a time, using round-robin grant. It presents each requester with the same read/write/waitrequest/valid handshake the DRAM port uses. It sits between the requesters and the DRAM controller.

## Interface
Parameters:
- ADDR_W, 22, address width
- DATA_W, 16, data width
- RD_TIMEOUT, 255, max cycles spent in RDWAIT before forced release

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_addr / b_addr  in  ADDR_W  requester address
- a_data_in / b_data_in  in  DATA_W  requester write data
- a_read / b_read, a_write / b_write  in  1  requester commands
- a_data_out / b_data_out  out  DATA_W  read data; both driven from ram_data_out
- a_valid / b_valid  out  1  read data valid for that port
- a_waitrq / b_waitrq  out  1  port stalled; low for exactly one cycle when the transaction completes
- ram_addr  out  ADDR_W  DRAM address
- ram_data_in  out  DATA_W  DRAM write data
- ram_read, ram_write  out  1  DRAM commands
- ram_data_out  in  DATA_W  DRAM read data
- ram_valid, ram_waitrq  in  1  DRAM handshake
- grant_b  out  1  status: 1 when B owns the port
- timeout_err  out  1  sticky; set on read timeout

## Operation
- Requesters hold addr, data, read and write stable until their waitrq goes low. Read and write asserted together is treated as a write.
- States:
  - IDLE: no owner.
  - CMD: forwards the owner's command.
  - RDWAIT: command accepted, awaiting data.
- IDLE:
  - Request from one port only: grant that port, go to CMD.
  - Both ports requesting: grant the port not in last_grant. last_grant resets to B, so A wins the first tie.
  - last_grant is updated on each grant.
- CMD:
  - ram_addr and ram_data_in are combinationally muxed from the owner. ram_write = owner write; ram_read = owner read && !owner write.
  - Write: when !ram_waitrq, owner waitrq goes low that cycle, then IDLE.
  - Read: when !ram_waitrq, go to RDWAIT. ram_valid seen in the same cycle completes the read immediately (see below), then IDLE.
- RDWAIT:
  - ram_read and ram_write are held low even if the owner still asserts read.
  - On ram_valid: owner valid=1 and owner waitrq=0 in the same cycle, then IDLE. This combined completion suits masters that wait for !waitrq && valid.
- Timeout: a counter starts at 0 on entry to RDWAIT. When it reaches RD_TIMEOUT: owner waitrq=0 with valid=0 for one cycle, timeout_err is set, go to IDLE.
- Non-owner port: waitrq=1 and valid=0 at all times.
- ram_valid seen in IDLE is ignored.
- In IDLE, ram_addr and ram_data_in are driven to 0.

## Timing
- Reset values (applied immediately on reset_n low):
  - state = IDLE, last_grant = B, counter = 0, timeout_err = 0.
  - ram_read = 0, ram_write = 0, ram_addr = 0, ram_data_in = 0.
  - a_waitrq = b_waitrq = 1, a_valid = b_valid = 0, grant_b = 0.
- Reset mid-transaction aborts it. The requester re-issues after reset.
- Latency, request to DRAM command: 1 cycle (request sampled in IDLE, command in CMD the next cycle).
- Minimum write: 2 cycles (IDLE, CMD with ram_waitrq=0).
- Minimum read: 2 cycles (ram_valid in the CMD acceptance cycle) or 3 cycles (ram_valid one cycle later).
- Back-to-back: one mandatory IDLE cycle between transactions. Both ports requesting continuously alternate A, B, A, …
- grant_b is registered and changes only on the IDLE→CMD transition.

## Configuration
- RAM_ARB_A_PRIORITY_EN:
  - Defined: fixed priority, A always wins a tie; last_grant is unused. This is for audio underrun protection.
  - Undefined (default): round-robin as described above.

## Test plan
- A writes 0x1234 to 0x000010, ram_waitrq high 3 cycles → ram_write asserted 4 cycles with ram_addr=0x000010, ram_data_in=0x1234; a_waitrq low exactly one cycle; b_waitrq stays 1.
- B reads 0x3FFFFF, ram_valid 2 cycles after acceptance with data 0xBEEF → b_valid=1, b_waitrq=0 and b_data_out=0xBEEF in the same cycle; ram_read low throughout RDWAIT.
- A and B request continuously from reset → grant order A, B, A, B. With RAM_ARB_A_PRIORITY_EN defined: A, A, A; B starves while A requests.
- Read with ram_valid never asserted → forced release after 255 RDWAIT cycles, port waitrq low with valid=0, timeout_err=1 until reset.
- reset_n pulled low mid-CMD with ram_write high → ram_write=0 immediately; after release the next grant goes to A.
- Port asserts read and write together → only ram_write is driven; no valid is produced.
